// File: rtl/bp_counter_table_sched.sv
// Scheduler for the shared single-port 2-bit counter table: sweeps the table after reset,
// then arbitrates lookups against queued read-modify-write updates. Optional stats: BPSCHED_STATS_EN.
module bp_counter_table_sched #(
    parameter int IDX_W     = 10,
    parameter int UQ_DEPTH  = 4,
    parameter int MAX_DEFER = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             lk_valid,
    input  logic [IDX_W-1:0] lk_idx,
    output logic             lk_ready,
    output logic             lk_resp_valid,
    output logic             lk_taken,
    output logic [1:0]       lk_ctr,
    input  logic             up_valid,
    input  logic [IDX_W-1:0] up_idx,
    input  logic             up_taken,
    output logic             up_ready,
    output logic             tbl_en,
    output logic             tbl_we,
    output logic [IDX_W-1:0] tbl_addr,
    output logic [1:0]       tbl_wdata,
    input  logic [1:0]       tbl_rdata,
    output logic             init_done
`ifdef BPSCHED_STATS_EN
    ,
    output logic [15:0]      stat_lookups,
    output logic [15:0]      stat_updates,
    output logic [15:0]      stat_forced
`endif
);

    localparam int QP_W  = (UQ_DEPTH > 1) ? $clog2(UQ_DEPTH) : 1;
    localparam int CNT_W = QP_W + 1;
    localparam int DEF_W = $clog2(MAX_DEFER + 1);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_UPD_WR = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [IDX_W-1:0]   ptr_r;
    logic               init_done_r;
    logic               resp_valid_r;
    logic [IDX_W-1:0]   q_idx_r [UQ_DEPTH];
    logic               q_tk_r  [UQ_DEPTH];
    logic [QP_W-1:0]    head_r;
    logic [QP_W-1:0]    tail_r;
    logic [CNT_W-1:0]   count_r;
    logic [DEF_W-1:0]   defer_r;

    logic               q_full_s;
    logic               q_empty_s;
    logic               force_s;
    logic               push_s;
    logic               pop_s;
    logic               upd_issue_s;
    logic               lk_ready_s;
    logic               up_ready_s;
    logic               tbl_en_s;
    logic               tbl_we_s;
    logic [IDX_W-1:0]   tbl_addr_s;
    logic [1:0]         tbl_wdata_s;
    logic [1:0]         lk_ctr_s;

    // Saturating 2-bit counter transition: SNT=0, WNT=1, WT=2, ST=3.
    function automatic logic [1:0] next_ctr(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        case ({taken, ctr})
            3'b1_00: res = 2'b01;
            3'b1_01: res = 2'b10;
            3'b1_10: res = 2'b11;
            3'b1_11: res = 2'b11;
            3'b0_00: res = 2'b00;
            3'b0_01: res = 2'b00;
            3'b0_10: res = 2'b01;
            3'b0_11: res = 2'b01;
            default: res = 2'b00;
        endcase
        return res;
    endfunction

    assign q_full_s   = (count_r == CNT_W'(UQ_DEPTH));
    assign q_empty_s  = (count_r == CNT_W'(0));
    assign force_s    = q_full_s || (defer_r == DEF_W'(MAX_DEFER));
    assign up_ready_s = init_done_r && !q_full_s && !reset;
    assign push_s     = up_valid && up_ready_s;

    // Next-state and table-port control; everything is held off while reset is asserted
    // so an in-flight update write cannot land in the reset cycle.
    always_comb begin
        state_s     = state_r;
        lk_ready_s  = 1'b0;
        tbl_en_s    = 1'b0;
        tbl_we_s    = 1'b0;
        tbl_addr_s  = '0;
        tbl_wdata_s = 2'b00;
        upd_issue_s = 1'b0;
        pop_s       = 1'b0;
        if (reset) begin
            state_s = ST_INIT;
        end else begin
            case (state_r)
                ST_INIT: begin
                    tbl_en_s   = 1'b1;
                    tbl_we_s   = 1'b1;
                    tbl_addr_s = ptr_r;
                    if (ptr_r == {IDX_W{1'b1}}) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_INIT;
                    end
                end
                ST_IDLE: begin
                    if (lk_valid && !force_s) begin
                        lk_ready_s = 1'b1;
                        tbl_en_s   = 1'b1;
                        tbl_addr_s = lk_idx;
                    end else if (!q_empty_s) begin
                        tbl_en_s    = 1'b1;
                        tbl_addr_s  = q_idx_r[head_r];
                        upd_issue_s = 1'b1;
                        state_s     = ST_UPD_WR;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_UPD_WR: begin
                    tbl_en_s    = 1'b1;
                    tbl_we_s    = 1'b1;
                    tbl_addr_s  = q_idx_r[head_r];
                    tbl_wdata_s = next_ctr(tbl_rdata, q_tk_r[head_r]);
                    pop_s       = 1'b1;
                    state_s     = ST_IDLE;
                end
                default: begin
                    state_s = ST_INIT;
                end
            endcase
        end
    end

    // FSM state, sweep pointer, init flag and lookup response pipeline.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_INIT;
            ptr_r        <= '0;
            init_done_r  <= 1'b0;
            resp_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            resp_valid_r <= lk_ready_s;
            if (state_r == ST_INIT) begin
                ptr_r <= ptr_r + IDX_W'(1);
            end else begin
                ptr_r <= ptr_r;
            end
            if ((state_r == ST_INIT) && (ptr_r == {IDX_W{1'b1}})) begin
                init_done_r <= 1'b1;
            end else begin
                init_done_r <= init_done_r;
            end
        end
    end

    // Update queue storage and pointers.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            for (int i = 0; i < UQ_DEPTH; i++) begin
                q_idx_r[i] <= '0;
                q_tk_r[i]  <= 1'b0;
            end
        end else begin
            if (push_s) begin
                q_idx_r[tail_r] <= up_idx;
                q_tk_r[tail_r]  <= up_taken;
                tail_r          <= tail_r + QP_W'(1);
            end
            if (pop_s) begin
                head_r <= head_r + QP_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Starvation counter: grows while lookups win over a waiting update.
    always_ff @(posedge clock) begin
        if (reset) begin
            defer_r <= '0;
        end else if (upd_issue_s) begin
            defer_r <= '0;
        end else if (lk_ready_s && !q_empty_s && (defer_r < DEF_W'(MAX_DEFER))) begin
            defer_r <= defer_r + DEF_W'(1);
        end else begin
            defer_r <= defer_r;
        end
    end

    assign lk_ctr_s      = resp_valid_r ? tbl_rdata : 2'b00;
    assign lk_ready      = lk_ready_s;
    assign lk_resp_valid = resp_valid_r;
    assign lk_ctr        = lk_ctr_s;
    assign lk_taken      = lk_ctr_s[1];
    assign up_ready      = up_ready_s;
    assign tbl_en        = tbl_en_s;
    assign tbl_we        = tbl_we_s;
    assign tbl_addr      = tbl_addr_s;
    assign tbl_wdata     = tbl_wdata_s;
    assign init_done     = init_done_r;

`ifdef BPSCHED_STATS_EN
    logic [15:0] stat_lookups_r;
    logic [15:0] stat_updates_r;
    logic [15:0] stat_forced_r;

    // Saturating activity counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_lookups_r <= 16'd0;
            stat_updates_r <= 16'd0;
            stat_forced_r  <= 16'd0;
        end else begin
            if (lk_ready_s && (stat_lookups_r != 16'hFFFF)) begin
                stat_lookups_r <= stat_lookups_r + 16'd1;
            end else begin
                stat_lookups_r <= stat_lookups_r;
            end
            if (pop_s && (stat_updates_r != 16'hFFFF)) begin
                stat_updates_r <= stat_updates_r + 16'd1;
            end else begin
                stat_updates_r <= stat_updates_r;
            end
            if (upd_issue_s && force_s && lk_valid && (stat_forced_r != 16'hFFFF)) begin
                stat_forced_r <= stat_forced_r + 16'd1;
            end else begin
                stat_forced_r <= stat_forced_r;
            end
        end
    end

    assign stat_lookups = stat_lookups_r;
    assign stat_updates = stat_updates_r;
    assign stat_forced  = stat_forced_r;
`endif

endmodule

// File: tb/tb_bp_counter_table_sched.sv
// Scoreboard bench for bp_counter_table_sched: external table RAM model, abstract
// counter/queue reference model, monitor comparing every lookup response and table write.
module tb_bp_counter_table_sched;

    localparam int IDX_W     = 4;
    localparam int UQ_DEPTH  = 4;
    localparam int MAX_DEFER = 8;
    localparam int DEPTH     = 16;

    logic             clock;
    logic             reset;
    logic             lk_valid;
    logic [IDX_W-1:0] lk_idx;
    logic             lk_ready;
    logic             lk_resp_valid;
    logic             lk_taken;
    logic [1:0]       lk_ctr;
    logic             up_valid;
    logic [IDX_W-1:0] up_idx;
    logic             up_taken;
    logic             up_ready;
    logic             tbl_en;
    logic             tbl_we;
    logic [IDX_W-1:0] tbl_addr;
    logic [1:0]       tbl_wdata;
    logic [1:0]       tbl_rdata;
    logic             init_done;
`ifdef BPSCHED_STATS_EN
    logic [15:0]      stat_lookups;
    logic [15:0]      stat_updates;
    logic [15:0]      stat_forced;
`endif

    bp_counter_table_sched #(.IDX_W(IDX_W), .UQ_DEPTH(UQ_DEPTH), .MAX_DEFER(MAX_DEFER)) dut (
        .clock(clock), .reset(reset),
        .lk_valid(lk_valid), .lk_idx(lk_idx), .lk_ready(lk_ready),
        .lk_resp_valid(lk_resp_valid), .lk_taken(lk_taken), .lk_ctr(lk_ctr),
        .up_valid(up_valid), .up_idx(up_idx), .up_taken(up_taken), .up_ready(up_ready),
        .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
        .tbl_rdata(tbl_rdata), .init_done(init_done)
`ifdef BPSCHED_STATS_EN
        , .stat_lookups(stat_lookups), .stat_updates(stat_updates), .stat_forced(stat_forced)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // External single-port table, seeded with garbage so the sweep matters.
    logic [1:0] mem [DEPTH];
    bit         mem_seeded = 1'b0;
    always @(posedge clock) begin
        if (!mem_seeded) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 2'($urandom_range(0, 3));
            mem_seeded <= 1'b1;
        end else if (tbl_en) begin
            if (tbl_we) mem[tbl_addr] <= tbl_wdata;
            else        tbl_rdata     <= mem[tbl_addr];
        end
    end

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             tk;
    } upd_t;

    upd_t       model_q[$];
    logic [1:0] exp_resp_q[$];
    logic [1:0] ref_tbl [DEPTH];
    int         init_exp;
    int         errors = 0;
    int         checks = 0;
    int         resp_count = 0;
    logic [1:0] last_resp_ctr = 2'b00;

    // Reference counter behaviour written as plain arithmetic.
    function automatic logic [1:0] model_next(input logic [1:0] c, input logic tk);
        int v;
        if (tk) v = (int'(c) >= 3) ? 3 : int'(c) + 1;
        else    v = (int'(c) >= 2) ? 1 : 0;
        return 2'(v);
    endfunction

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on responses and writes, pushes on grants/accepts.
    always @(negedge clock) begin
        logic [1:0] e;
        upd_t       u;
        if (reset) begin
            model_q.delete();
            exp_resp_q.delete();
            init_exp = 0;
        end else begin
            if (lk_resp_valid) begin
                if (exp_resp_q.size() == 0) begin
                    check(1'b0, "unexpected_resp", int'(lk_ctr), 0);
                end else begin
                    e = exp_resp_q.pop_front();
                    check(lk_ctr == e && lk_taken == e[1], "lookup_ctr", int'({lk_taken, lk_ctr}), int'({e[1], e}));
                    last_resp_ctr = lk_ctr;
                    resp_count++;
                end
            end
            if (tbl_en && tbl_we) begin
                if (!init_done) begin
                    check(int'(tbl_addr) == init_exp && tbl_wdata == 2'b00 && init_exp < DEPTH,
                          "init_write", int'({tbl_addr, tbl_wdata}), init_exp * 4);
                    ref_tbl[tbl_addr] = 2'b00;
                    init_exp++;
                end else if (model_q.size() == 0) begin
                    check(1'b0, "unexpected_write", int'(tbl_addr), -1);
                end else begin
                    u = model_q.pop_front();
                    e = model_next(ref_tbl[u.idx], u.tk);
                    check(tbl_addr == u.idx && tbl_wdata == e, "update_write",
                          int'({tbl_addr, tbl_wdata}), int'({u.idx, e}));
                    ref_tbl[u.idx] = e;
                end
            end
            if (lk_valid && lk_ready) exp_resp_q.push_back(ref_tbl[lk_idx]);
            if (up_valid && up_ready) model_q.push_back('{idx: up_idx, tk: up_taken});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_update(input int idx, input bit tk);
        bit ok;
        ok       = 1'b0;
        up_valid = 1'b1;
        up_idx   = IDX_W'(idx);
        up_taken = tk;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (up_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        up_valid = 1'b0;
        if (!ok) check(1'b0, "push_timeout", 0, 1);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (model_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check(1'b0, "drain_timeout", model_q.size(), 0);
        repeat (2) tick();
    endtask

    task automatic lookup_one(input int idx);
        bit ok;
        ok       = 1'b0;
        lk_valid = 1'b1;
        lk_idx   = IDX_W'(idx);
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (lk_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        lk_valid = 1'b0;
        repeat (2) tick();
        if (!ok) check(1'b0, "lookup_timeout", 0, 1);
    endtask

    initial begin
        int grants;
        int rc0;
        int rst_idx;
        int cyc;
        bit found;
        logic [IDX_W-1:0] fill_idx [4];
        logic             fill_tk  [4];

        reset = 1'b1; lk_valid = 1'b0; lk_idx = '0;
        up_valid = 1'b0; up_idx = '0; up_taken = 1'b0;
        repeat (3) tick();
        @(negedge clock);
        check(lk_ready == 1'b0, "rst_lk_ready", lk_ready, 0);
        check(up_ready == 1'b0, "rst_up_ready", up_ready, 0);
        check(lk_resp_valid == 1'b0, "rst_resp_valid", lk_resp_valid, 0);
        check(init_done == 1'b0, "rst_init_done", init_done, 0);

        // Release reset with a lookup already pending; 16 sweep cycles, grant on cycle 17.
        tick();
        reset = 1'b0; lk_valid = 1'b1; lk_idx = IDX_W'(0);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clock);
            check(init_done == 1'b0 && lk_ready == 1'b0 && up_ready == 1'b0 && tbl_en && tbl_we,
                  "init_cycle", c, c);
            tick();
        end
        @(negedge clock);
        check(init_done == 1'b1, "init_done_c17", init_done, 1);
        check(lk_ready == 1'b1, "grant_c17", lk_ready, 1);
        tick();
        lk_valid = 1'b0;
        repeat (2) tick();

        // Single entry saturation and decay.
        repeat (4) push_update(5, 1'b1);
        drain();
        lk_valid = 1'b1; lk_idx = IDX_W'(5);
        repeat (4) tick();
        lk_valid = 1'b0;
        repeat (3) tick();
        check(last_resp_ctr == 2'd3, "single_entry_st", last_resp_ctr, 3);
        push_update(5, 1'b0);
        drain();
        lookup_one(5);
        check(last_resp_ctr == 2'd1, "single_entry_wnt", last_resp_ctr, 1);

        // Randomized mixed traffic on a small index range to provoke same-index hazards.
        for (int k = 0; k < 400; k++) begin
            lk_valid = ($urandom_range(0, 3) != 0);
            lk_idx   = IDX_W'($urandom_range(0, 7));
            up_valid = ($urandom_range(0, 2) == 0);
            up_idx   = IDX_W'($urandom_range(0, 7));
            up_taken = 1'($urandom_range(0, 1));
            tick();
        end
        lk_valid = 1'b0; up_valid = 1'b0;
        drain();

        // Lookup pipeline: eight back-to-back grants and responses.
        rc0 = resp_count;
        lk_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            lk_idx = IDX_W'(i);
            @(negedge clock);
            check(lk_ready == 1'b1, "pipe_grant", lk_ready, 1);
            if (i > 0) check(lk_resp_valid == 1'b1, "pipe_b2b_resp", lk_resp_valid, 1);
            tick();
        end
        lk_valid = 1'b0;
        @(negedge clock);
        check(lk_resp_valid == 1'b1, "pipe_last_resp", lk_resp_valid, 1);
        repeat (2) tick();
        check(resp_count - rc0 == 8, "pipe_resp_count", resp_count - rc0, 8);

        // Starvation: exactly MAX_DEFER grants then the update goes through.
        lk_valid = 1'b1; lk_idx = IDX_W'($urandom_range(0, 15));
        push_update(2, 1'b1);
        grants = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (!lk_ready) break;
            grants++;
            tick();
            lk_idx = IDX_W'($urandom_range(0, 15));
        end
        check(grants == MAX_DEFER, "starve_grants", grants, MAX_DEFER);
        tick();
        @(negedge clock);
        check(lk_ready == 1'b0 && tbl_we == 1'b1, "starve_upd_wr", int'({lk_ready, tbl_we}), 1);
        tick();
        @(negedge clock);
        check(lk_ready == 1'b1, "starve_resume", lk_ready, 1);
        tick();
        lk_valid = 1'b0;
        drain();

        // Full queue under continuous lookups; index 10 updated twice.
        fill_idx[0] = 4'd10; fill_tk[0] = 1'b1;
        fill_idx[1] = 4'd11; fill_tk[1] = 1'b0;
        fill_idx[2] = 4'd12; fill_tk[2] = 1'b1;
        fill_idx[3] = 4'd10; fill_tk[3] = 1'b1;
        lk_valid = 1'b1; lk_idx = IDX_W'(0);
        up_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_idx = fill_idx[i]; up_taken = fill_tk[i];
            @(negedge clock);
            check(up_ready == 1'b1, "fill_ready", up_ready, 1);
            tick();
        end
        up_valid = 1'b0;
        @(negedge clock);
        check(up_ready == 1'b0, "full_up_ready", up_ready, 0);
        check(lk_ready == 1'b0, "full_force", lk_ready, 0);
        drain();
        lk_valid = 1'b0;
        repeat (2) tick();
        lookup_one(10);
        check(last_resp_ctr == 2'd2, "full_idx10", last_resp_ctr, 2);
        lookup_one(11);
        lookup_one(12);
        check(last_resp_ctr == 2'd1, "full_idx12", last_resp_ctr, 1);

        // Synchronous reset landing on an update write cycle.
        push_update(9, 1'b1);
        push_update(9, 1'b1);
        drain();
        lookup_one(9);
        check(last_resp_ctr == 2'd2, "pre_rst_idx9", last_resp_ctr, 2);
        push_update(9, 1'b0);
        push_update(3, 1'b1);
        push_update(6, 1'b1);
        found = 1'b0; rst_idx = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (tbl_en && !tbl_we && init_done && model_q.size() == 2) begin
                found = 1'b1;
                rst_idx = int'(tbl_addr);
                break;
            end
            tick();
        end
        check(found, "rst_find_upd_read", found, 1);
        tick();
        reset = 1'b1;
        @(negedge clock);
        check(!(tbl_en && tbl_we && int'(tbl_addr) == rst_idx), "rst_no_upd_write",
              int'({tbl_en, tbl_we}), 0);
        tick();
        reset = 1'b0;
        cyc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (init_done) break;
            cyc++;
            tick();
        end
        check(cyc == 16, "rst_resweep_len", cyc, 16);
        repeat (10) tick();
        lookup_one(rst_idx);
        check(last_resp_ctr == 2'd0, "rst_idx_cleared", last_resp_ctr, 0);
        lookup_one(9);
        check(last_resp_ctr == 2'd0, "rst_idx9_cleared", last_resp_ctr, 0);
        repeat (3) tick();

        check(exp_resp_q.size() == 0, "resp_queue_empty", exp_resp_q.size(), 0);
        check(model_q.size() == 0, "update_queue_empty", model_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
